vred_seq_ctrl: RTL

//  Issues element pairs to vRedSum_min_max_unit_block (2-cycle pairwise reduction unit) and folds a

---
 rtl/vred_pkg.sv | 30 +++
 rtl/vred_tag_pipe.sv | 40 ++++
 rtl/vred_seq_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/vred_pkg.sv
// Shared types and constants for the vector reduction sequencer.
package vred_pkg;

    // Cycles from issuing a pair to the reduction unit until red_result is valid.
    localparam int RED_LATENCY_DEF = 2;

    // Operation select codes: bit1 = min/max family, bit0 = max.
    localparam logic [1:0] OP_SUM = 2'b00;
    localparam logic [1:0] OP_MIN = 2'b10;
    localparam logic [1:0] OP_MAX = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STREAM  = 3'd1,
        DRAIN   = 3'd2,
        COMBINE = 3'd3,
        WAIT    = 3'd4,
        DONE    = 3'd5
    } state_t;

    typedef enum logic {
        LANE_A = 1'b0,
        LANE_B = 1'b1
    } lane_t;

    function automatic lane_t other_lane(input lane_t l);
        return (l == LANE_A) ? LANE_B : LANE_A;
    endfunction

endpackage

// File: rtl/vred_tag_pipe.sv
// Tracks which accumulator lane each in-flight unit operation belongs to.
// A tag pushed in the issue cycle pops out exactly DEPTH cycles later,
// aligned with the unit's red_result.
module vred_tag_pipe
    import vred_pkg::*;
#(
    parameter int DEPTH = RED_LATENCY_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push_valid,
    input  lane_t push_lane,
    output logic  ret_valid,
    output lane_t ret_lane,
    output logic  empty
);

    logic [DEPTH-1:0] vld_q;
    lane_t            lane_q [DEPTH];

    // Shift tags one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) lane_q[i] <= LANE_A;
        end else begin
            vld_q[0]  <= push_valid;
            lane_q[0] <= push_lane;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                lane_q[i] <= lane_q[i-1];
            end
        end
    end

    assign ret_valid = vld_q[DEPTH-1];
    assign ret_lane  = lane_q[DEPTH-1];
    assign empty     = ~|vld_q;

endmodule

// File: rtl/vred_seq_ctrl.sv
// Sequencer that folds a streamed vector into one scalar using an external
// pipelined pairwise reduction unit. Two interleaved accumulator lanes hide
// the unit latency so one element can be accepted every cycle; a final
// combine pass merges the lanes.
//
// Handshakes (start, elem, res) are valid/ready: a beat transfers on a rising
// edge where both valid and ready are high; the sender holds payload stable
// while valid is high and ready is low.
module vred_seq_ctrl
    import vred_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int VL_WIDTH    = 8,
    parameter int RED_LATENCY = RED_LATENCY_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [VL_WIDTH-1:0]     start_vl,
    input  logic [1:0]              start_sew,
    input  logic [1:0]              start_opsel,
    input  logic [DATA_WIDTH-1:0]   start_scalar,
    input  logic                    elem_valid,
    output logic                    elem_ready,
    input  logic [DATA_WIDTH-1:0]   elem_data,
    input  logic                    elem_mask,
    output logic [2*DATA_WIDTH-1:0] red_vec,
    output logic                    red_en,
    output logic [1:0]              red_sew,
    output logic [1:0]              red_opsel,
    input  logic [DATA_WIDTH-1:0]   red_result,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic                    busy,
    output state_t                  dbg_state
);

    state_t                state_q;
    logic [VL_WIDTH-1:0]   vl_q;
    logic [VL_WIDTH-1:0]   cnt_q;
    logic [1:0]            sew_q;
    logic [1:0]            opsel_q;
    lane_t                 lane_q;
    logic [DATA_WIDTH-1:0] acc_a_q;
    logic [DATA_WIDTH-1:0] acc_b_q;
    // Lane B holds (or has in flight) a value once its first element is loaded.
    logic                  acc_b_vld_q;
    logic [DATA_WIDTH-1:0] res_data_q;
    logic                  res_valid_q;

    logic                  consume;
    logic                  push_valid;
    lane_t                 push_lane;
    logic                  ret_valid;
    lane_t                 ret_lane;
    logic                  tp_empty;
    logic [DATA_WIDTH-1:0] acc_src;

    vred_tag_pipe #(.DEPTH(RED_LATENCY)) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_lane  (push_lane),
        .ret_valid  (ret_valid),
        .ret_lane   (ret_lane),
        .empty      (tp_empty)
    );

    assign start_ready = (state_q == IDLE);
    assign elem_ready  = (state_q == STREAM) && (cnt_q < vl_q);
    assign consume     = elem_valid && elem_ready;
    assign busy        = (state_q != IDLE);
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign red_sew     = sew_q;
    assign red_opsel   = opsel_q;
    assign dbg_state   = state_q;

    // Issue mux: pick the pair for this cycle, bypassing a same-lane result
    // that lands this cycle so back-to-back elements never see a stale acc.
    always_comb begin
        push_valid = 1'b0;
        push_lane  = LANE_A;
        red_vec    = '0;
        red_en     = 1'b0;
        acc_src    = (lane_q == LANE_A) ? acc_a_q : acc_b_q;
        if (ret_valid && (ret_lane == lane_q)) acc_src = red_result;
        if (consume && elem_mask) begin
            push_valid = 1'b1;
            push_lane  = lane_q;
            if ((lane_q == LANE_B) && !acc_b_vld_q) begin
                red_vec = {{DATA_WIDTH{1'b0}}, elem_data};
            end else begin
                red_vec = {elem_data, acc_src};
                red_en  = 1'b1;
            end
        end else if (state_q == COMBINE) begin
            push_valid = 1'b1;
            push_lane  = LANE_A;
            red_vec    = {acc_b_q, acc_a_q};
            red_en     = 1'b1;
        end
    end

    // Control FSM with accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vl_q        <= '0;
            cnt_q       <= '0;
            sew_q       <= '0;
            opsel_q     <= '0;
            lane_q      <= LANE_A;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            acc_b_vld_q <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (ret_valid) begin
                if (ret_lane == LANE_A) begin
                    acc_a_q <= red_result;
                end else begin
                    acc_b_q     <= red_result;
                    acc_b_vld_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        vl_q        <= start_vl;
                        sew_q       <= start_sew;
                        opsel_q     <= start_opsel;
                        acc_a_q     <= start_scalar;
                        acc_b_q     <= '0;
                        acc_b_vld_q <= 1'b0;
                        cnt_q       <= '0;
                        lane_q      <= LANE_A;
                        if (start_vl == '0) begin
                            res_data_q  <= start_scalar;
                            res_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (consume) begin
                        cnt_q <= cnt_q + VL_WIDTH'(1);
                        if (elem_mask) begin
                            lane_q <= other_lane(lane_q);
                            if (lane_q == LANE_B) acc_b_vld_q <= 1'b1;
                        end
                        if ((cnt_q + VL_WIDTH'(1)) == vl_q) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (tp_empty) begin
                        if (!acc_b_vld_q) begin
                            res_data_q  <= acc_a_q;
                            res_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= COMBINE;
                        end
                    end
                end
                COMBINE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (ret_valid) begin
                        res_data_q  <= red_result;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
